// File: rtl/rv_outstanding_limiter.sv
// rv_outstanding_limiter: caps in-flight requests with a 1-entry request register and a 2-entry response skid buffer.
// Optional watchdog: define RV_LIMITER_TIMEOUT_EN to enable the timeout flag.
module rv_outstanding_limiter #(
    parameter int DATA_WIDTH      = 16,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] up_req_data,
    input  logic                  up_req_valid,
    output logic                  up_req_ready,
    output logic [DATA_WIDTH-1:0] up_rsp_data,
    output logic                  up_rsp_valid,
    input  logic                  up_rsp_ready,
    output logic [DATA_WIDTH-1:0] dn_req_data,
    output logic                  dn_req_valid,
    input  logic                  dn_req_ready,
    input  logic [DATA_WIDTH-1:0] dn_rsp_data,
    input  logic                  dn_rsp_valid,
    output logic                  dn_rsp_ready,
    output logic [3:0]            outstanding,
    output logic                  err_unexpected_rsp,
    output logic                  timeout
);
    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 15 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_cfg
        $error("rv_outstanding_limiter: parameter out of range");
    end
    logic                  req_full;
    logic [DATA_WIDTH-1:0] req_data;
    logic [DATA_WIDTH-1:0] rsp_mem [2];
    logic                  rd_ptr, wr_ptr, rsp_rdy, err_q;
    logic [1:0]            rsp_cnt, rsp_cnt_next;
    logic [3:0]            out_q, cap;
    logic                  up_req_hs, up_rsp_hs, dn_req_hs, dn_rsp_hs, drop, push, dec;
    // Handshakes, slot accounting and the drop decision for unsolicited responses
    always_comb begin
        up_rsp_hs    = (rsp_cnt != 2'd0) & up_rsp_ready;
        dec          = up_rsp_hs & (out_q != 4'd0);
        cap          = out_q - {3'd0, dec};
        up_req_ready = (~req_full | dn_req_ready) & (cap < 4'(MAX_OUTSTANDING));
        up_req_hs    = up_req_valid & up_req_ready;
        dn_req_hs    = req_full & dn_req_ready;
        dn_rsp_hs    = dn_rsp_valid & rsp_rdy;
        drop         = dn_rsp_hs & (out_q == 4'd0) & ~up_req_hs;
        push         = dn_rsp_hs & ~drop;
        rsp_cnt_next = rsp_cnt + {1'b0, push} - {1'b0, up_rsp_hs};
    end
    assign dn_req_valid       = req_full;
    assign dn_req_data        = req_data;
    assign up_rsp_valid       = rsp_cnt != 2'd0;
    assign up_rsp_data        = rsp_mem[rd_ptr];
    assign dn_rsp_ready       = rsp_rdy;
    assign outstanding        = out_q;
    assign err_unexpected_rsp = err_q;
    // Request forward register, in-flight count and sticky unexpected-response flag
    always_ff @(posedge clk) begin
        if (rst) begin
            req_full <= 1'b0;
            out_q    <= 4'd0;
            err_q    <= 1'b0;
        end else begin
            if (dn_req_hs) req_full <= 1'b0;
            if (up_req_hs) begin
                req_full <= 1'b1;
                req_data <= up_req_data;
            end
            out_q <= out_q + {3'd0, up_req_hs} - {3'd0, dec};
            err_q <= err_q | drop;
        end
    end
    // Two-entry response skid buffer; ready is registered from the next occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_cnt <= 2'd0;
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            rsp_rdy <= 1'b1;
        end else begin
            if (push) begin
                rsp_mem[wr_ptr] <= dn_rsp_data;
                wr_ptr          <= ~wr_ptr;
            end
            if (up_rsp_hs) rd_ptr <= ~rd_ptr;
            rsp_cnt <= rsp_cnt_next;
            rsp_rdy <= rsp_cnt_next != 2'd2;
        end
    end
`ifdef RV_LIMITER_TIMEOUT_EN
    logic [15:0] wd, wd_next;
    logic        to_q;
    // Watchdog: counts idle-response cycles while requests are in flight, saturating at the limit
    always_comb begin
        wd_next = (dn_rsp_hs || out_q == 4'd0) ? 16'd0 : (wd == 16'(TIMEOUT_CYCLES) ? wd : wd + 16'd1);
    end
    // Watchdog counter and sticky timeout flag
    always_ff @(posedge clk) begin
        if (rst) begin
            wd   <= 16'd0;
            to_q <= 1'b0;
        end else begin
            wd   <= wd_next;
            to_q <= to_q | (wd_next == 16'(TIMEOUT_CYCLES));
        end
    end
    assign timeout = to_q;
`else
    assign timeout = 1'b0;
`endif
endmodule
